hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit_if.sv | 41 ++++
 rtl/hazard_unit.sv | 143 ++++++++++++++
 tb/tb_hazard_unit.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_unit_if.sv
// Hazard unit signal bundle: pipeline-stage register indices in, control and forwarding out.
interface hazard_unit_if;
  localparam int unsigned REG_W = 2;

  logic [REG_W-1:0] d_ra;
  logic [REG_W-1:0] d_rb;
  logic             d_use_ra;
  logic             d_use_rb;
  logic [REG_W-1:0] e_ra;
  logic [REG_W-1:0] e_rb;
  logic [REG_W-1:0] e_rd;
  logic             e_RW;
  logic             e_memrd;
  logic [REG_W-1:0] m_rd;
  logic             m_RW;
  logic [REG_W-1:0] w_rd;
  logic             w_RW;
  logic             e_br_taken;
  logic             e_Hlt;

  logic             pc_ld;
  logic             fd_ld;
  logic             de_ld;
  logic             fd_flush;
  logic             de_flush;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             halted;

  modport master (
    output d_ra, d_rb, d_use_ra, d_use_rb, e_ra, e_rb, e_rd, e_RW, e_memrd,
           m_rd, m_RW, w_rd, w_RW, e_br_taken, e_Hlt,
    input  pc_ld, fd_ld, de_ld, fd_flush, de_flush, fwd_a, fwd_b, halted
  );

  modport slave (
    input  d_ra, d_rb, d_use_ra, d_use_rb, e_ra, e_rb, e_rd, e_RW, e_memrd,
           m_rd, m_RW, w_rd, w_RW, e_br_taken, e_Hlt,
    output pc_ld, fd_ld, de_ld, fd_flush, de_flush, fwd_a, fwd_b, halted
  );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: stall/flush/halt sequencing plus Ex operand forwarding.
// Optional feature macro HAZARD_FWD_EN: enables Mem/WB forwarding and reduces
// stalls to a single bubble on load-use; without it every RAW hazard against
// Ex or Mem stalls until the producer reaches writeback.
// Pipeline controls are combinational from state and current inputs because
// they must act in the same cycle the hazard, branch or reset is seen.
module hazard_unit (
  input  logic          clk,
  input  logic          reset,
  hazard_unit_if.slave  hz
);
  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic             match_e;
  logic             match_m;
  logic             stall_req;
  logic [CNT_W-1:0] stall_len;
  logic [1:0]       fwd_a_c;
  logic [1:0]       fwd_b_c;

  logic             pc_ld_c, fd_ld_c, de_ld_c, fd_flush_c, de_flush_c;

  // Decode instruction reads a register that an older in-flight instruction writes
  assign match_e = (hz.d_use_ra && (hz.d_ra == hz.e_rd)) ||
                   (hz.d_use_rb && (hz.d_rb == hz.e_rd));
  assign match_m = (hz.d_use_ra && (hz.d_ra == hz.m_rd)) ||
                   (hz.d_use_rb && (hz.d_rb == hz.m_rd));

`ifdef HAZARD_FWD_EN
  // Only a load result is too late to forward; one bubble covers it
  assign stall_req = hz.e_RW && hz.e_memrd && match_e;
  assign stall_len = CNT_W'(1);

  // Mem result is younger than WB result, so it wins when both match
  always_comb begin
    fwd_a_c = 2'b00;
    fwd_b_c = 2'b00;
    if (hz.m_RW && (hz.m_rd == hz.e_ra))      fwd_a_c = 2'b01;
    else if (hz.w_RW && (hz.w_rd == hz.e_ra)) fwd_a_c = 2'b10;
    if (hz.m_RW && (hz.m_rd == hz.e_rb))      fwd_b_c = 2'b01;
    else if (hz.w_RW && (hz.w_rd == hz.e_rb)) fwd_b_c = 2'b10;
  end
`else
  // Without forwarding wait for the producer to reach WB (write-before-read there)
  assign stall_req = (hz.e_RW && match_e) || (hz.m_RW && match_m);
  assign stall_len = (hz.e_RW && match_e) ? CNT_W'(2) : CNT_W'(1);
  assign fwd_a_c   = 2'b00;
  assign fwd_b_c   = 2'b00;

  logic unused_fwd_c;
  assign unused_fwd_c = ^{hz.e_ra, hz.e_rb, hz.e_memrd, hz.w_rd, hz.w_RW};
`endif

  // State register and remaining-bubble counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next state and pipeline controls; priority reset > branch > halt > stall > run.
  // The RUN cycle that detects a hazard is the first bubble, so stall_cnt holds
  // the bubbles still owed after it and STALL leaves when the last one is issued.
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    pc_ld_c     = 1'b1;
    fd_ld_c     = 1'b1;
    de_ld_c     = 1'b1;
    fd_flush_c  = 1'b0;
    de_flush_c  = 1'b0;

    if (!reset) begin
      pc_ld_c     = 1'b0;
      fd_ld_c     = 1'b0;
      de_ld_c     = 1'b0;
      fd_flush_c  = 1'b1;
      de_flush_c  = 1'b1;
      state_d     = S_RUN;
      stall_cnt_d = '0;
    end else if (state_q == S_HALT) begin
      pc_ld_c    = 1'b0;
      fd_ld_c    = 1'b0;
      de_ld_c    = 1'b0;
      fd_flush_c = 1'b1;
      de_flush_c = 1'b1;
    end else if (hz.e_br_taken) begin
      fd_flush_c  = 1'b1;
      de_flush_c  = 1'b1;
      state_d     = S_RUN;
      stall_cnt_d = '0;
    end else if (hz.e_Hlt) begin
      pc_ld_c     = 1'b0;
      fd_ld_c     = 1'b0;
      de_flush_c  = 1'b1;
      state_d     = S_HALT;
      stall_cnt_d = '0;
    end else if (state_q == S_STALL) begin
      pc_ld_c    = 1'b0;
      fd_ld_c    = 1'b0;
      de_flush_c = 1'b1;
      if (stall_cnt_q <= CNT_W'(1)) begin
        state_d     = S_RUN;
        stall_cnt_d = '0;
      end else begin
        stall_cnt_d = stall_cnt_q - CNT_W'(1);
      end
    end else if (stall_req) begin
      pc_ld_c    = 1'b0;
      fd_ld_c    = 1'b0;
      de_flush_c = 1'b1;
      if (stall_len > CNT_W'(1)) begin
        state_d     = S_STALL;
        stall_cnt_d = stall_len - CNT_W'(1);
      end
    end else begin
      stall_cnt_d = '0;
    end
  end

  // Drive the bundle; forwarding is suppressed while reset is held
  assign hz.pc_ld    = pc_ld_c;
  assign hz.fd_ld    = fd_ld_c;
  assign hz.de_ld    = de_ld_c;
  assign hz.fd_flush = fd_flush_c;
  assign hz.de_flush = de_flush_c;
  assign hz.fwd_a    = reset ? fwd_a_c : 2'b00;
  assign hz.fwd_b    = reset ? fwd_b_c : 2'b00;
  assign hz.halted   = reset && (state_q == S_HALT);
endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit; works with or without HAZARD_FWD_EN.
module tb_hazard_unit;
`ifdef HAZARD_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  // pc_ld fd_ld de_ld fd_flush de_flush
  localparam logic [4:0] C_RUN   = 5'b11100;
  localparam logic [4:0] C_STALL = 5'b00101;
  localparam logic [4:0] C_BR    = 5'b11111;
  localparam logic [4:0] C_HLTIN = 5'b00101;
  localparam logic [4:0] C_HALT  = 5'b00011;
  localparam logic [4:0] C_RST   = 5'b00011;

  typedef struct packed {
    logic       reset;
    logic [1:0] d_ra;
    logic [1:0] d_rb;
    logic       d_use_ra;
    logic       d_use_rb;
    logic [1:0] e_ra;
    logic [1:0] e_rb;
    logic [1:0] e_rd;
    logic       e_RW;
    logic       e_memrd;
    logic [1:0] m_rd;
    logic       m_RW;
    logic [1:0] w_rd;
    logic       w_RW;
    logic       e_br_taken;
    logic       e_Hlt;
  } in_t;

  typedef struct packed {
    logic [4:0] ctl;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       halted;
  } outs_t;

  logic  clk;
  logic  reset;
  int    n_vec;
  int    n_err;
  outs_t exp_q[$];

  hazard_unit_if hz();

  hazard_unit dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t idle();
    in_t v;
    v       = '0;
    v.reset = 1'b1;
    return v;
  endfunction

  function automatic logic [1:0] fwd_model(input logic [1:0] src, input in_t v);
    if (!v.reset || !FWD_EN)          return 2'b00;
    if (v.m_RW && (v.m_rd == src))    return 2'b01;
    if (v.w_RW && (v.w_rd == src))    return 2'b10;
    return 2'b00;
  endfunction

  function automatic outs_t mk(input logic [4:0] ctl, input in_t v, input logic h);
    outs_t o;
    o.ctl    = ctl;
    o.fwd_a  = fwd_model(v.e_ra, v);
    o.fwd_b  = fwd_model(v.e_rb, v);
    o.halted = h;
    return o;
  endfunction

  function automatic outs_t sample();
    outs_t o;
    o.ctl    = {hz.pc_ld, hz.fd_ld, hz.de_ld, hz.fd_flush, hz.de_flush};
    o.fwd_a  = hz.fwd_a;
    o.fwd_b  = hz.fwd_b;
    o.halted = hz.halted;
    return o;
  endfunction

  task automatic drive(input in_t v, input outs_t e);
    reset         = v.reset;
    hz.d_ra       = v.d_ra;
    hz.d_rb       = v.d_rb;
    hz.d_use_ra   = v.d_use_ra;
    hz.d_use_rb   = v.d_use_rb;
    hz.e_ra       = v.e_ra;
    hz.e_rb       = v.e_rb;
    hz.e_rd       = v.e_rd;
    hz.e_RW       = v.e_RW;
    hz.e_memrd    = v.e_memrd;
    hz.m_rd       = v.m_rd;
    hz.m_RW       = v.m_RW;
    hz.w_rd       = v.w_rd;
    hz.w_RW       = v.w_RW;
    hz.e_br_taken = v.e_br_taken;
    hz.e_Hlt      = v.e_Hlt;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    in_t v[3]; outs_t e[3]; outs_t got, ex;
    v[0] = idle(); v[0].reset = 1'b0; v[0].m_RW = 1'b1;  // would forward if not in reset
    v[1] = v[0];
    v[2] = idle();
    e[0] = mk(C_RST, v[0], 1'b0);
    e[1] = mk(C_RST, v[1], 1'b0);
    e[2] = mk(C_RUN, v[2], 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(v[i], e[i]);
      @(negedge clk);
      got = sample(); ex = exp_q.pop_front(); n_vec++;
      if (got !== ex) begin
        n_err++;
        $display("FAIL reset[%0d] got=%b required=%b", i, got, ex);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_forwarding();
    in_t v[4]; outs_t e[4]; outs_t got, ex;
    v[0] = idle(); v[0].m_rd = 2'd1; v[0].m_RW = 1'b1; v[0].w_rd = 2'd1; v[0].w_RW = 1'b1;
    v[0].e_ra = 2'd1; v[0].e_rb = 2'd3;
    v[1] = v[0]; v[1].m_RW = 1'b0;
    v[2] = v[0]; v[2].m_rd = 2'd3;
    v[3] = v[0]; v[3].m_RW = 1'b0; v[3].w_RW = 1'b0;
    for (int i = 0; i < 4; i++) e[i] = mk(C_RUN, v[i], 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(v[i], e[i]);
      @(negedge clk);
      got = sample(); ex = exp_q.pop_front(); n_vec++;
      if (got !== ex) begin
        n_err++;
        $display("FAIL forwarding[%0d] got=%b required=%b", i, got, ex);
      end
      @(posedge clk); #1;
    end
  endtask

  // Producer load in Ex, then Mem, then WB while the consumer waits in Decode
  task automatic test_load_use();
    in_t v[3]; outs_t e[3]; outs_t got, ex;
    v[0] = idle(); v[0].d_ra = 2'd2; v[0].d_use_ra = 1'b1;
    v[0].e_rd = 2'd2; v[0].e_RW = 1'b1; v[0].e_memrd = 1'b1;
    v[1] = idle(); v[1].d_ra = 2'd2; v[1].d_use_ra = 1'b1; v[1].m_rd = 2'd2; v[1].m_RW = 1'b1;
    v[2] = idle(); v[2].d_ra = 2'd2; v[2].d_use_ra = 1'b1; v[2].w_rd = 2'd2; v[2].w_RW = 1'b1;
    e[0] = mk(C_STALL, v[0], 1'b0);
    e[1] = mk(FWD_EN ? C_RUN : C_STALL, v[1], 1'b0);
    e[2] = mk(C_RUN, v[2], 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(v[i], e[i]);
      @(negedge clk);
      got = sample(); ex = exp_q.pop_front(); n_vec++;
      if (got !== ex) begin
        n_err++;
        $display("FAIL load_use[%0d] got=%b required=%b", i, got, ex);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall_boundaries();
    in_t v[8]; outs_t e[8]; outs_t got, ex;
    v[0] = idle(); v[0].e_rd = 2'd1; v[0].e_RW = 1'b1; v[0].d_ra = 2'd1; v[0].d_use_ra = 1'b1;
    v[1] = idle();
    v[2] = idle();
    v[3] = idle(); v[3].m_rd = 2'd2; v[3].m_RW = 1'b1; v[3].d_rb = 2'd2; v[3].d_use_rb = 1'b1;
    v[4] = idle();
    v[5] = idle(); v[5].e_rd = 2'd1; v[5].e_RW = 1'b1; v[5].e_memrd = 1'b1;
    v[5].d_ra = 2'd1; v[5].d_rb = 2'd2; v[5].d_use_rb = 1'b1;
    v[6] = idle(); v[6].e_rd = 2'd1; v[6].e_memrd = 1'b1; v[6].d_ra = 2'd1; v[6].d_use_ra = 1'b1;
    v[7] = idle(); v[7].w_rd = 2'd1; v[7].w_RW = 1'b1; v[7].d_ra = 2'd1; v[7].d_use_ra = 1'b1;
    e[0] = mk(FWD_EN ? C_RUN : C_STALL, v[0], 1'b0);
    e[1] = mk(FWD_EN ? C_RUN : C_STALL, v[1], 1'b0);
    e[2] = mk(C_RUN, v[2], 1'b0);
    e[3] = mk(FWD_EN ? C_RUN : C_STALL, v[3], 1'b0);
    e[4] = mk(C_RUN, v[4], 1'b0);
    e[5] = mk(C_RUN, v[5], 1'b0);
    e[6] = mk(C_RUN, v[6], 1'b0);
    e[7] = mk(C_RUN, v[7], 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive(v[i], e[i]);
      @(negedge clk);
      got = sample(); ex = exp_q.pop_front(); n_vec++;
      if (got !== ex) begin
        n_err++;
        $display("FAIL stall_boundaries[%0d] got=%b required=%b", i, got, ex);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_in_stall();
    in_t v[5]; outs_t e[5]; outs_t got, ex;
    v[0] = idle(); v[0].e_rd = 2'd3; v[0].e_RW = 1'b1; v[0].e_memrd = 1'b1;
    v[0].d_rb = 2'd3; v[0].d_use_rb = 1'b1;
    v[1] = v[0]; v[1].e_br_taken = 1'b1;
    v[2] = idle();
    v[3] = v[1];
    v[4] = idle();
    e[0] = mk(C_STALL, v[0], 1'b0);
    e[1] = mk(C_BR,    v[1], 1'b0);
    e[2] = mk(C_RUN,   v[2], 1'b0);
    e[3] = mk(C_BR,    v[3], 1'b0);
    e[4] = mk(C_RUN,   v[4], 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(v[i], e[i]);
      @(negedge clk);
      got = sample(); ex = exp_q.pop_front(); n_vec++;
      if (got !== ex) begin
        n_err++;
        $display("FAIL branch_in_stall[%0d] got=%b required=%b", i, got, ex);
      end
      @(posedge clk); #1;
    end
  endtask

  // Branch beats halt, halt beats stall, HALT ignores everything but reset
  task automatic test_halt();
    localparam int N = 17;
    in_t v[N]; outs_t e[N]; outs_t got, ex;
    logic [$bits(in_t)-1:0] r;
    v[0] = idle(); v[0].e_Hlt = 1'b1; v[0].e_br_taken = 1'b1;
    v[1] = idle();
    v[2] = idle(); v[2].e_Hlt = 1'b1; v[2].e_rd = 2'd1; v[2].e_RW = 1'b1; v[2].e_memrd = 1'b1;
    v[2].d_ra = 2'd1; v[2].d_use_ra = 1'b1;
    e[0] = mk(C_BR,    v[0], 1'b0);
    e[1] = mk(C_RUN,   v[1], 1'b0);
    e[2] = mk(C_HLTIN, v[2], 1'b0);
    for (int i = 3; i < 15; i++) begin
      r = $bits(in_t)'($urandom);
      v[i] = r; v[i].reset = 1'b1;
      e[i] = mk(C_HALT, v[i], 1'b1);
    end
    r = $bits(in_t)'($urandom);
    v[15] = r; v[15].reset = 1'b0;
    e[15] = mk(C_RST, v[15], 1'b0);
    v[16] = idle();
    e[16] = mk(C_RUN, v[16], 1'b0);
    for (int i = 0; i < N; i++) begin
      drive(v[i], e[i]);
      @(negedge clk);
      got = sample(); ex = exp_q.pop_front(); n_vec++;
      if (got !== ex) begin
        n_err++;
        $display("FAIL halt[%0d] got=%b required=%b", i, got, ex);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_stall();
    in_t v[3]; outs_t e[3]; outs_t got, ex;
    v[0] = idle(); v[0].e_rd = 2'd2; v[0].e_RW = 1'b1; v[0].e_memrd = 1'b1;
    v[0].d_rb = 2'd2; v[0].d_use_rb = 1'b1;
    v[1] = v[0]; v[1].reset = 1'b0;
    v[2] = idle();
    e[0] = mk(C_STALL, v[0], 1'b0);
    e[1] = mk(C_RST,   v[1], 1'b0);
    e[2] = mk(C_RUN,   v[2], 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(v[i], e[i]);
      @(negedge clk);
      got = sample(); ex = exp_q.pop_front(); n_vec++;
      if (got !== ex) begin
        n_err++;
        $display("FAIL reset_mid_stall[%0d] got=%b required=%b", i, got, ex);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_forwarding();
    test_load_use();
    test_stall_boundaries();
    test_branch_in_stall();
    test_halt();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
